// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
// Purpose: receive side of the two-digit seven-segment display interface.
//   Watches a pair of segment buses, waits until they have been stable for
//   STABLE_CYCLES synchronized samples, then decodes them back to a hex byte.
//   Each new stable pattern is reported exactly once. The report is either a
//   data_valid pulse with the byte, or a pattern_err pulse when either digit
//   is not a hex glyph.
// Parameters:
//   STABLE_CYCLES - equal consecutive samples needed before commit (1..255)
//   ACTIVE_LOW    - 1: segment inputs are active-low, 0: active-high
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   disp1       - low-nibble digit segments, bit6=a .. bit0=g
//   disp2       - high-nibble digit segments, same bit order
//   data_out    - last successfully decoded byte {disp2 nibble, disp1 nibble}
//   data_valid  - one-cycle pulse when data_out updates
//   pattern_err - one-cycle pulse when a stable pattern fails to decode
//   error_count - saturating count of pattern_err pulses
module seven_segment_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] disp1,
   input  logic [6:0] disp2,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       pattern_err,
   output logic [7:0] error_count
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      COMMIT = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [13:0] raw;
   logic [13:0] sync1_p0;
   logic [13:0] sync2_p1;
   logic [13:0] s_prev_p2;
   logic [13:0] committed;
   logic [7:0]  cnt;
   logic        same;
   logic        stable;
   logic        commit_go;
   logic        changed;
   logic        commit_upd;
   logic        ev_valid;
   logic        ev_err;
   logic [4:0]  dec_hi;
   logic [4:0]  dec_lo;

   // Returns {ok, nibble} for an active-high segment pattern.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      case (seg)
         7'h7E:   decode_glyph = {1'b1, 4'h0};
         7'h30:   decode_glyph = {1'b1, 4'h1};
         7'h6D:   decode_glyph = {1'b1, 4'h2};
         7'h79:   decode_glyph = {1'b1, 4'h3};
         7'h33:   decode_glyph = {1'b1, 4'h4};
         7'h5B:   decode_glyph = {1'b1, 4'h5};
         7'h5F:   decode_glyph = {1'b1, 4'h6};
         7'h70:   decode_glyph = {1'b1, 4'h7};
         7'h7F:   decode_glyph = {1'b1, 4'h8};
         7'h7B:   decode_glyph = {1'b1, 4'h9};
         7'h77:   decode_glyph = {1'b1, 4'hA};
         7'h1F:   decode_glyph = {1'b1, 4'hB};
         7'h4E:   decode_glyph = {1'b1, 4'hC};
         7'h3D:   decode_glyph = {1'b1, 4'hD};
         7'h4F:   decode_glyph = {1'b1, 4'hE};
         7'h47:   decode_glyph = {1'b1, 4'hF};
         default: decode_glyph = 5'h00;
      endcase
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      sat_inc = (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Polarity is normalised ahead of the synchronizer, so a cleared
   // synchronizer reads as a blank display. That equals the reset value
   // of the committed pattern, so reset never produces a phantom event.
   assign raw = {disp2, disp1} ^ {14{ACTIVE_LOW}};

   // ---- stage p0/p1: two-flop synchronizer, p2: previous sample + stability counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_p0  <= '0;
         sync2_p1  <= '0;
         s_prev_p2 <= '0;
         cnt       <= '0;
      end else begin
         sync1_p0  <= raw;
         sync2_p1  <= sync1_p0;
         s_prev_p2 <= sync2_p1;
         if (!same)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 8'd1;
      end
   end

   assign same    = (sync2_p1 == s_prev_p2);
   assign stable  = same && (cnt == CNT_MAX);
   assign changed = (sync2_p1 != committed);
   assign dec_hi  = decode_glyph(sync2_p1[13:7]);
   assign dec_lo  = decode_glyph(sync2_p1[6:0]);

   // ---- FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= SETTLE;
      else
         state <= state_nxt;
   end

   // Commit is decided in the last SETTLE cycle and its result is registered
   // on the edge into COMMIT, so the event pulse coincides with COMMIT.
   always_comb begin
      state_nxt = state;
      case (state)
         SETTLE:  if (stable) state_nxt = COMMIT;
         COMMIT:  state_nxt = same ? HOLD : SETTLE;
         HOLD:    if (!same) state_nxt = SETTLE;
         default: state_nxt = SETTLE;
      endcase
   end

   always_comb begin
      commit_go  = (state == SETTLE) && stable;
      commit_upd = commit_go && changed;
      ev_valid   = commit_upd && dec_hi[4] && dec_lo[4];
      ev_err     = commit_upd && !(dec_hi[4] && dec_lo[4]);
   end

   // ---- event registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         committed   <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         pattern_err <= 1'b0;
         error_count <= '0;
      end else begin
         data_valid  <= ev_valid;
         pattern_err <= ev_err;
         if (commit_upd)
            committed <= sync2_p1;
         if (ev_valid)
            data_out <= {dec_hi[3:0], dec_lo[3:0]};
         if (ev_err)
            error_count <= sat_inc(error_count);
      end
   end

endmodule

// File: tb/tb_seven_segment_decoder.sv
module tb_seven_segment_decoder;

   localparam int S    = 4;
   localparam int WAIT = S + 6;

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      logic [7:0] ecnt;
   } evt_t;

   typedef struct {
      logic [6:0] seg2;
      logic [6:0] seg1;
      logic [7:0] exp_data;
      logic [7:0] exp_ecnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [13:0] pat = '0;   // active-high {disp2, disp1}

   logic [6:0] d1_l, d2_l, d1_h, d2_h;
   logic [7:0] do_l, do_h, ec_l, ec_h;
   logic       dv_l, dv_h, pe_l, pe_h;

   assign d2_h = pat[13:7];
   assign d1_h = pat[6:0];
   assign d2_l = ~pat[13:7];
   assign d1_l = ~pat[6:0];

   seven_segment_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut_l (
      .clk(clk), .rst_n(rst_n), .disp1(d1_l), .disp2(d2_l),
      .data_out(do_l), .data_valid(dv_l), .pattern_err(pe_l), .error_count(ec_l));

   seven_segment_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut_h (
      .clk(clk), .rst_n(rst_n), .disp1(d1_h), .disp2(d2_h),
      .data_out(do_h), .data_valid(dv_h), .pattern_err(pe_h), .error_count(ec_h));

   always #5 clk = ~clk;

   logic [6:0] GLYPH [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_ev_cyc [2] = '{-1, -1};
   evt_t q_l [$];
   evt_t q_h [$];

   logic [13:0] m_committed = '0;
   logic [7:0]  m_data = '0;
   logic [7:0]  m_ecnt = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit glyph_lookup(input logic [6:0] g, output logic [3:0] n);
      n = '0;
      for (int i = 0; i < 16; i++)
         if (GLYPH[i] == g) begin
            n = 4'(i);
            return 1'b1;
         end
      return 1'b0;
   endfunction

   task automatic expect_pattern(input logic [13:0] p);
      logic [3:0] hi, lo;
      bit okh, okl;
      evt_t e;
      if (p == m_committed) return;
      m_committed = p;
      okh = glyph_lookup(p[13:7], hi);
      okl = glyph_lookup(p[6:0], lo);
      if (okh && okl) begin
         m_data = {hi, lo};
         e.is_err = 1'b0;
      end else begin
         if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
         e.is_err = 1'b1;
      end
      e.data = m_data;
      e.ecnt = m_ecnt;
      q_l.push_back(e);
      q_h.push_back(e);
   endtask

   task automatic check_evt(input int idx, input logic dv, input logic pe,
                            input logic [7:0] d, input logic [7:0] ec);
      evt_t e;
      int   qs;
      if (!dv && !pe) return;
      last_ev_cyc[idx] = cyc;
      tests++;
      if (dv && pe) begin
         fails++;
         $display("FAIL both_pulses dut%0d: valid=%b err=%b, required not both high", idx, dv, pe);
         return;
      end
      qs = (idx == 0) ? q_l.size() : q_h.size();
      if (qs == 0) begin
         fails++;
         $display("FAIL unexpected_event dut%0d: valid=%b err=%b data=%h, required no event", idx, dv, pe, d);
         return;
      end
      e = (idx == 0) ? q_l.pop_front() : q_h.pop_front();
      if (e.is_err != pe || d != e.data || ec != e.ecnt) begin
         fails++;
         $display("FAIL event dut%0d: err=%b data=%h ecnt=%h, required err=%b data=%h ecnt=%h",
                  idx, pe, d, ec, e.is_err, e.data, e.ecnt);
      end
   endtask

   always @(negedge clk) begin
      check_evt(0, dv_l, pe_l, do_l, ec_l);
      check_evt(1, dv_h, pe_h, do_h, ec_h);
   end

   task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, got, want);
      end
   endtask

   task automatic check_int(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   task automatic check_drained(input string name);
      tests++;
      if (q_l.size() != 0 || q_h.size() != 0) begin
         fails++;
         $display("FAIL %s: missing events l=%0d h=%0d, required 0", name, q_l.size(), q_h.size());
         q_l.delete();
         q_h.delete();
      end
   endtask

   task automatic apply(input logic [13:0] p, input string name);
      @(posedge clk);
      #1 pat = p;
      expect_pattern(p);
      repeat (WAIT) @(posedge clk);
      check_drained(name);
   endtask

   task automatic check_outs_zero(input string name);
      check8({name, "_data_l"}, do_l, 8'h00);
      check8({name, "_dv_l"}, {7'b0, dv_l}, 8'h00);
      check8({name, "_pe_l"}, {7'b0, pe_l}, 8'h00);
      check8({name, "_ec_l"}, ec_l, 8'h00);
      check8({name, "_data_h"}, do_h, 8'h00);
      check8({name, "_ec_h"}, ec_h, 8'h00);
   endtask

   vec_t vecs [8];

   initial begin
      int c0;
      int n;
      logic [13:0] kp;
      logic [3:0]  tmp;
      logic [7:0]  bv;

      vecs[0] = '{7'h30, 7'h7E, 8'h10, 8'h01};
      vecs[1] = '{7'h4E, 7'h77, 8'hCA, 8'h01};
      vecs[2] = '{7'h7F, 7'h00, 8'hCA, 8'h02};
      vecs[3] = '{7'h47, 7'h5B, 8'hF5, 8'h02};
      vecs[4] = '{7'h7E, 7'h7E, 8'h00, 8'h02};
      vecs[5] = '{7'h33, 7'h1F, 8'h4B, 8'h02};
      vecs[6] = '{7'h2A, 7'h3D, 8'h4B, 8'h03};
      vecs[7] = '{7'h79, 7'h6D, 8'h32, 8'h03};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outs_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (WAIT) @(posedge clk);
      check_drained("blank_after_reset");

      // 0xA5 with latency check (disp1=7'h24, disp2=7'h08 active-low)
      @(posedge clk);
      #1 pat = {~7'h08, ~7'h24};
      c0 = cyc;
      expect_pattern(pat);
      repeat (WAIT) @(posedge clk);
      check_drained("a5_event");
      check_int("a5_latency_l", last_ev_cyc[0], c0 + S + 3);
      check_int("a5_latency_h", last_ev_cyc[1], c0 + S + 3);
      check8("a5_data_l", do_l, 8'hA5);

      // Hold for 50 cycles: no repeat event
      repeat (50) @(posedge clk);
      check_drained("a5_hold");
      check8("a5_hold_data", do_l, 8'hA5);

      // Short glitch on disp1 then restore: no event
      @(posedge clk);
      #1 pat[6:0] = ~7'h01;
      repeat (2) @(posedge clk);
      #1 pat[6:0] = ~7'h24;
      repeat (WAIT + 4) @(posedge clk);
      check_drained("glitch");
      check8("glitch_data_l", do_l, 8'hA5);
      check8("glitch_data_h", do_h, 8'hA5);

      // Only segment g lit on disp1: invalid
      apply({~7'h08, ~7'h7E}, "g_only");
      check8("g_only_data", do_l, 8'hA5);
      check8("g_only_ecnt_l", ec_l, 8'h01);
      check8("g_only_ecnt_h", ec_h, 8'h01);

      // Table-driven vectors
      for (int i = 0; i < 8; i++) begin
         apply({vecs[i].seg2, vecs[i].seg1}, "vec");
         check8($sformatf("vec%0d_data_l", i), do_l, vecs[i].exp_data);
         check8($sformatf("vec%0d_data_h", i), do_h, vecs[i].exp_data);
         check8($sformatf("vec%0d_ecnt_l", i), ec_l, vecs[i].exp_ecnt);
      end

      // 300 distinct invalid patterns: error_count saturates
      n = 0;
      for (int k = 0; k < 16384 && n < 300; k++) begin
         kp = k[13:0];
         if (!(glyph_lookup(kp[13:7], tmp) && glyph_lookup(kp[6:0], tmp)) && kp != m_committed) begin
            apply(kp, "invalid_sweep");
            n++;
         end
      end
      check8("sat_ecnt_l", ec_l, 8'hFF);
      check8("sat_ecnt_h", ec_h, 8'hFF);
      check8("sat_data_l", do_l, 8'h32);

      // 0x3C interrupted by reset at E3
      @(posedge clk);
      #1 pat = {~7'h06, ~7'h31};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check_outs_zero("mid_reset");
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      c0 = cyc;
      m_committed = '0;
      m_data = '0;
      m_ecnt = '0;
      check_drained("pre_reset_no_pulse");
      expect_pattern(pat);
      repeat (WAIT) @(posedge clk);
      check_drained("post_reset_3c");
      check_int("post_reset_latency", last_ev_cyc[0], c0 + S + 3);
      check8("post_reset_data_l", do_l, 8'h3C);
      check8("post_reset_data_h", do_h, 8'h3C);

      // Sweep all bytes
      for (int b = 0; b < 256; b++) begin
         bv = b[7:0];
         apply({GLYPH[bv[7:4]], GLYPH[bv[3:0]]}, "sweep");
         check8($sformatf("sweep_%h_l", bv), do_l, bv);
         check8($sformatf("sweep_%h_h", bv), do_h, bv);
      end
      check8("sweep_ecnt", ec_l, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
